// File: rtl/ftdi_rx_packetizer.sv
// FT232H async 245-FIFO read front end: syncs RXF#, times the RD# strobe, captures ADBUS
// and presents bytes as a valid/ready stream framed into fixed-length packets.
module ftdi_rx_packetizer #(
  parameter int PKT_BYTES   = 128,
  parameter int RD_LOW_CYC  = 3,
  parameter int RD_HIGH_CYC = 5,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ftdi_rxf_n,
  output logic       ftdi_rd_n,
  input  logic [7:0] adbus_in,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_first,
  output logic       out_last,
  output logic       pkt_done,
  output logic       rx_timeout,
  output logic [7:0] pkt_count
);
  localparam int IDX_W   = $clog2(PKT_BYTES);
  localparam int CNT_MAX = (RD_LOW_CYC > RD_HIGH_CYC) ? RD_LOW_CYC : RD_HIGH_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(RD_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(RD_HIGH_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PKT_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, RD_LOW, RD_HIGH} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             capture;
  logic             rxf_m, rxf_s;
  logic [IDX_W-1:0] byte_idx;
  logic [TO_W-1:0]  idle_cnt;
  logic             accept;

  assign accept = out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      rxf_m <= 1'b1;
      rxf_s <= 1'b1;
    end else begin
      rxf_m <= ftdi_rxf_n;
      rxf_s <= rxf_m;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ftdi_rd_n <= 1'b1;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      // Registered strobe: low exactly while the FSM sits in RD_LOW.
      ftdi_rd_n <= (state_nx != RD_LOW);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (!rxf_s && !out_valid) begin
          state_nx = RD_LOW;
          cnt_nx   = LOW_LOAD;
        end
      end
      RD_LOW: begin
        if (cnt == '0) begin
          capture  = 1'b1;
          state_nx = RD_HIGH;
          cnt_nx   = HIGH_LOAD;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      RD_HIGH: begin
        if (cnt == '0) state_nx = IDLE;
        else           cnt_nx   = cnt - 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_count <= '0;
    end else begin
      pkt_done <= accept && out_last;
      if (accept) begin
        out_valid <= 1'b0;
        if (out_last) pkt_count <= pkt_count + 8'd1;
      end
      // Reads only start with out_valid low, so capture never overlaps accept.
      if (capture) begin
        out_data  <= adbus_in;
        out_valid <= 1'b1;
        out_first <= (byte_idx == '0);
        out_last  <= (byte_idx == IDX_LAST);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      byte_idx   <= '0;
      idle_cnt   <= '0;
      rx_timeout <= 1'b0;
    end else begin
      rx_timeout <= 1'b0;
      if (capture) begin
        byte_idx <= (byte_idx == IDX_LAST) ? '0 : byte_idx + 1'b1;
        idle_cnt <= '0;
      end else if (byte_idx == '0) begin
        idle_cnt <= '0;
      end else if (state == IDLE && !out_valid) begin
        if (idle_cnt == TO_LAST) begin
          byte_idx   <= '0;
          idle_cnt   <= '0;
          rx_timeout <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ftdi_rx_packetizer.sv
// Directed bench: reset, strobe timing, packet framing, back-pressure, timeout, count wrap.
module tb_ftdi_rx_packetizer;
  logic       clock = 1'b0;
  logic       reset;
  logic       rxf_n, rd_n, out_ready, out_valid, out_first, out_last, pkt_done, rx_timeout;
  logic [7:0] adbus, out_data, pkt_count;
  logic       rxf_n2, rd_n2, ready2, valid2, first2, last2, pkt_done2, rx_timeout2;
  logic [7:0] adbus2, data2, pkt_count2;

  int n_chk = 0, n_fail = 0;
  int n_strobe = 0, n_done = 0, n_to = 0;

  always #5 clock = ~clock;

  ftdi_rx_packetizer #(.PKT_BYTES(128), .RD_LOW_CYC(3), .RD_HIGH_CYC(5), .TIMEOUT_CYC(100)) dut (
    .clock(clock), .reset(reset), .ftdi_rxf_n(rxf_n), .ftdi_rd_n(rd_n), .adbus_in(adbus),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_first(out_first),
    .out_last(out_last), .pkt_done(pkt_done), .rx_timeout(rx_timeout), .pkt_count(pkt_count));

  ftdi_rx_packetizer #(.PKT_BYTES(2), .RD_LOW_CYC(3), .RD_HIGH_CYC(5), .TIMEOUT_CYC(50000)) dut2 (
    .clock(clock), .reset(reset), .ftdi_rxf_n(rxf_n2), .ftdi_rd_n(rd_n2), .adbus_in(adbus2),
    .out_data(data2), .out_valid(valid2), .out_ready(ready2), .out_first(first2),
    .out_last(last2), .pkt_done(pkt_done2), .rx_timeout(rx_timeout2), .pkt_count(pkt_count2));

  always @(negedge rd_n) n_strobe++;
  always @(negedge clock) begin
    if (pkt_done)   n_done++;
    if (rx_timeout) n_to++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps at least once, then until out_valid is seen; reports an expired bound.
  task automatic wait_valid(input string tag);
    int t;
    t = 0;
    do begin step(); t++; end while (!out_valid && t < 40);
    if (!out_valid) chk({tag, "_valid_timeout"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    int t, s0, d0, to0, err, c;
    logic ef, el;
    reset = 1'b1; rxf_n = 1'b0; out_ready = 1'b1; adbus = 8'hA5;
    rxf_n2 = 1'b1; ready2 = 1'b1; adbus2 = 8'h5A;

    // Reset held two cycles with RXF# low
    for (int k = 0; k < 2; k++) begin
      step();
      chk("rst_rd_n", 32'(rd_n), 32'd1);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_flags", {29'd0, out_first, out_last, pkt_done}, 32'd0);
      chk("rst_count", 32'(pkt_count), 32'd0);
    end
    reset = 1'b0;
    step(); chk("lat_e1", 32'(rd_n), 32'd1);
    step(); chk("lat_e2", 32'(rd_n), 32'd1);
    step(); chk("lat_e3", 32'(rd_n), 32'd0);

    // Single byte: RD# low for exactly 3 cycles, capture on the last
    step(); chk("low_c2", 32'(rd_n), 32'd0); chk("low_c2_valid", 32'(out_valid), 32'd0);
    step(); chk("low_c3", 32'(rd_n), 32'd0);
    step(); chk("rise", 32'(rd_n), 32'd1);
    chk("a5_valid", 32'(out_valid), 32'd1);
    chk("a5_data", 32'(out_data), 32'hA5);
    chk("a5_first", 32'(out_first), 32'd1);
    chk("a5_last", 32'(out_last), 32'd0);
    step(); chk("a5_accepted", 32'(out_valid), 32'd0);
    t = 1;
    while (rd_n && t < 20) begin step(); t++; end
    chk("rise_to_fall", 32'(t), 32'd6);

    // Reset mid-strobe releases RD# and drops the byte
    reset = 1'b1;
    step();
    chk("midrst_rd_n", 32'(rd_n), 32'd1);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;

    // Two full 128-byte packets
    s0 = n_strobe; d0 = n_done; err = 0;
    for (int i = 1; i <= 256; i++) begin
      adbus = 8'(i);
      wait_valid("stream");
      ef = (i == 1) || (i == 129);
      el = (i == 128) || (i == 256);
      if (out_data !== 8'(i) || out_first !== ef || out_last !== el) err++;
      if (i == 256) rxf_n = 1'b1;
    end
    chk("stream_byte_errs", 32'(err), 32'd0);
    repeat (20) step();
    chk("stream_strobes", 32'(n_strobe - s0), 32'd256);
    chk("stream_pkt_done", 32'(n_done - d0), 32'd2);
    chk("stream_pkt_count", 32'(pkt_count), 32'd2);

    // Back-pressure: one strobe, data held until accepted
    s0 = n_strobe;
    out_ready = 1'b0; adbus = 8'h3C; rxf_n = 1'b0;
    wait_valid("bp");
    chk("bp_data", 32'(out_data), 32'h3C);
    chk("bp_first", 32'(out_first), 32'd1);
    adbus = 8'hC3;
    repeat (40) step();
    chk("bp_held_valid", 32'(out_valid), 32'd1);
    chk("bp_held_data", 32'(out_data), 32'h3C);
    chk("bp_one_strobe", 32'(n_strobe - s0), 32'd1);
    out_ready = 1'b1;
    step();
    chk("bp_accept", 32'(out_valid), 32'd0);
    chk("bp_no_same_cycle_read", 32'(rd_n), 32'd1);
    step();
    chk("bp_next_strobe", 32'(rd_n), 32'd0);
    wait_valid("bp2");
    rxf_n = 1'b1;
    chk("bp2_data", 32'(out_data), 32'hC3);
    chk("bp2_first", 32'(out_first), 32'd0);
    reset = 1'b1;
    step(); step();
    reset = 1'b0;

    // Timeout on a 10-byte partial packet
    to0 = n_to; d0 = n_done;
    rxf_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      adbus = 8'(i + 16);
      wait_valid("to_fill");
      if (i == 10) rxf_n = 1'b1;
    end
    t = 0;
    do begin step(); t++; end while (!rx_timeout && t < 300);
    chk("to_latency", 32'(t), 32'd105);
    step();
    chk("to_pulse_width", 32'(rx_timeout), 32'd0);
    chk("to_pulse_count", 32'(n_to - to0), 32'd1);
    chk("to_pkt_count", 32'(pkt_count), 32'd0);
    chk("to_no_done", 32'(n_done - d0), 32'd0);
    adbus = 8'h77; rxf_n = 1'b0;
    wait_valid("to_next");
    rxf_n = 1'b1;
    chk("to_next_data", 32'(out_data), 32'h77);
    chk("to_next_first", 32'(out_first), 32'd1);

    // 256 two-byte packets wrap the counter
    rxf_n2 = 1'b0;
    c = 0; t = 0;
    while (c < 256 && t < 8000) begin
      step(); t++;
      if (pkt_done2) begin
        c++;
        if (c == 255) chk("wrap_count_255", 32'(pkt_count2), 32'd255);
      end
    end
    chk("wrap_done_pulses", 32'(c), 32'd256);
    chk("wrap_count_0", 32'(pkt_count2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ftdi_rx_packetizer.md
Name: ftdi_rx_packetizer

Overview:
- Read-side front end between the FT232H asynchronous 245-FIFO pins and the packet/echo logic.
- Synchronises RXF#, runs the RD# strobe with programmable low/recovery times and captures ADBUS bytes.
- Presents the bytes as a valid/ready stream framed into fixed-length packets (first/last markers).
- Tracks completed packets and aborts a stalled partial packet on timeout.

Parameters:
- PKT_BYTES, 128: bytes per packet; must be ≥2.
- RD_LOW_CYC, 3: clock cycles RD# is held low; ADBUS is sampled on the last of these cycles; must be ≥1.
- RD_HIGH_CYC, 5: recovery cycles with RD# high before RXF# is looked at again; must be ≥1.
- TIMEOUT_CYC, 50000: idle cycles allowed inside a partial packet before it is aborted.

Ports:
- clock, input, 1: system clock (50 MHz).
- reset, input, 1: synchronous, active-high reset.
- ftdi_rxf_n, input, 1: FT232H RXF#, asynchronous; low means a byte is available.
- ftdi_rd_n, output, 1: FT232H RD# strobe, registered.
- adbus_in, input, 8: ADBUS data from the pad.
- out_data, output, 8: captured byte.
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: consumer accepts the byte when out_valid && out_ready.
- out_first, output, 1: the current byte is index 0 of its packet.
- out_last, output, 1: the current byte is index PKT_BYTES-1.
- pkt_done, output, 1: one-cycle pulse when a last byte is accepted.
- rx_timeout, output, 1: one-cycle pulse when a partial packet is aborted.
- pkt_count, output, 8: completed packets; wraps from 255 to 0.

Behaviour:
- Reset values:
  - ftdi_rd_n=1, out_valid=0, out_data=0, out_first=0, out_last=0.
  - pkt_done=0, rx_timeout=0, pkt_count=0, byte_idx=0, idle counter=0.
  - Synchroniser flops reset to 1; state=IDLE.
- Reset applied mid-strobe releases RD# high on the next edge and discards the byte in flight.
- RXF# synchronisation: two-flop synchroniser producing rxf_s. All decisions use rxf_s only.
- State machine:
  - IDLE: if rxf_s==0 and out_valid==0, go to RD_LOW and drive ftdi_rd_n=0 from the next cycle. Otherwise stay in IDLE.
  - RD_LOW: ftdi_rd_n=0 for exactly RD_LOW_CYC cycles (down-counter). On the final cycle:
    - adbus_in is registered into out_data and out_valid is set.
    - out_first is set to (byte_idx==0) and out_last to (byte_idx==PKT_BYTES-1).
    - byte_idx advances, wrapping PKT_BYTES-1 → 0.
    - Next state is RD_HIGH.
  - RD_HIGH: ftdi_rd_n=1 for exactly RD_HIGH_CYC cycles, ignoring rxf_s. Then go to IDLE.
- Latency and throughput:
  - From rxf_n falling (settled before an edge) to rd_n low: 3 edges.
  - Minimum byte period is 1+RD_LOW_CYC+RD_HIGH_CYC cycles when out_ready is held high.
- Output handshake:
  - out_valid stays high and out_data/first/last hold until accepted; out_valid clears on the cycle after acceptance.
  - No new read starts while out_valid=1. This is a single-entry buffer and no byte is ever dropped.
  - A read cannot start in the same cycle as an acceptance; it starts from IDLE on the next cycle.
- Packet completion: on acceptance of a byte with out_last=1, pkt_done pulses for one cycle and pkt_count increments modulo 256.
- Timeout:
  - The idle counter counts while byte_idx!=0, state==IDLE and out_valid==0. It clears on any capture or whenever byte_idx==0.
  - When it reaches TIMEOUT_CYC: byte_idx←0, rx_timeout pulses for one cycle, the counter clears and pkt_count is unchanged.
  - If a capture coincides with the timeout cycle, the capture wins and there is no timeout.
- RXF# rising during RD_LOW does not shorten the strobe; the byte is still captured.
- ADBUS is input-only here. Direction control belongs to the write-side block.

Test Plan:
- Reset: hold reset 2 cycles with rxf_n=0 → rd_n stays 1 and all outputs are 0 throughout. After release, rd_n falls on the 3rd edge.
- Single byte, RD_LOW_CYC=3, RD_HIGH_CYC=5, out_ready=1:
  - Stimulus: rxf_n=0 with adbus=8'hA5 while rd_n is low.
  - Required: rd_n low for exactly 3 cycles; out_data=A5 and out_first=1; the next rd_n fall comes no earlier than 6 cycles after the rise.
- Full packets: stream bytes 1..128 with rxf_n low and out_ready=1, twice.
  - out_first only on byte 1; out_last only on byte 128.
  - pkt_done pulses twice; pkt_count=2.
  - 256 strobes in total, with no extra strobes.
- Back-pressure: out_ready=0 for 40 cycles after the first byte with rxf_n held low.
  - Exactly one strobe occurs and out_data is held.
  - Raising out_ready gives acceptance, after which the next strobe begins.
- Timeout with TIMEOUT_CYC=100: deliver 10 bytes, then rxf_n=1.
  - rx_timeout pulses once, 100 cycles after the idle state is entered; pkt_count=0.
  - The next byte has out_first=1.
- Wrap: complete 256 packets with PKT_BYTES=2 → pkt_count returns to 0 and pkt_done fires 256 times.
